// File: rtl/ram512_arbiter_pkg.sv
// rtl/ram512_arbiter_pkg.sv - shared constants and types for the ram512 arbiter
package ram512_arbiter_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int WORDS  = 512;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_A = 1'b0;
    localparam req_id_t REQ_B = 1'b1;

endpackage

// File: rtl/ram512_arbiter_if.sv
// rtl/ram512_arbiter_if.sv - requester A/B and fill-control signal bundle
interface ram512_arbiter_if;
    import ram512_arbiter_pkg::*;

    logic              a_valid;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ready;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_valid;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ready;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic              fill_start;
    logic [DATA_W-1:0] fill_value;
    logic              fill_busy;
    logic              fill_done;

    modport master (
        output a_valid, a_we, a_addr, a_wdata,
        input  a_ready, a_rvalid, a_rdata,
        output b_valid, b_we, b_addr, b_wdata,
        input  b_ready, b_rvalid, b_rdata,
        output fill_start, fill_value,
        input  fill_busy, fill_done
    );

    modport slave (
        input  a_valid, a_we, a_addr, a_wdata,
        output a_ready, a_rvalid, a_rdata,
        input  b_valid, b_we, b_addr, b_wdata,
        output b_ready, b_rvalid, b_rdata,
        input  fill_start, fill_value,
        output fill_busy, fill_done
    );

endinterface

// File: rtl/ram512.sv
// rtl/ram512.sv - 512x16 storage, combinational read, synchronous write on load
module ram512
    import ram512_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              load,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (load) begin
            mem[addr] <= din;
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/ram512_arbiter.sv
// rtl/ram512_arbiter.sv - round-robin sharing of one ram512 between A and B, plus a fill engine
module ram512_arbiter
    import ram512_arbiter_pkg::*;
#(
    parameter int FIRST_PRIO = 0
)
(
    input  logic           clk,
    input  logic           reset,
    ram512_arbiter_if.slave bus
);

    localparam req_id_t LAST_INIT = (FIRST_PRIO == 0) ? REQ_B : REQ_A;

    state_t            state_q, state_d;
    req_id_t           last_q, last_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] fill_val_q, fill_val_d;
    logic              fill_done_q, fill_done_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic              grant_a, grant_b;
    logic              ram_load;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din, ram_dout;

    ram512 u_ram (
        .clk  (clk),
        .load (ram_load),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    // Grants and the RAM port mux are kept apart from next-state logic so the
    // read-data path through the RAM is not seen as a combinational loop.
    always_comb begin
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        ram_load = 1'b0;
        ram_addr = bus.a_addr;
        ram_din  = bus.a_wdata;
        case (state_q)
            ST_IDLE: begin
                if (!bus.fill_start) begin
                    grant_a = bus.a_valid && (!bus.b_valid || last_q == REQ_B);
                    grant_b = bus.b_valid && (!bus.a_valid || last_q == REQ_A);
                end
                if (grant_a) begin
                    ram_load = bus.a_we;
                end else if (grant_b) begin
                    ram_load = bus.b_we;
                    ram_addr = bus.b_addr;
                    ram_din  = bus.b_wdata;
                end
            end
            ST_FILL: begin
                ram_load = 1'b1;
                ram_addr = cnt_q;
                ram_din  = fill_val_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        fill_val_d  = fill_val_q;
        fill_done_d = 1'b0;
        a_rvalid_d  = grant_a;
        b_rvalid_d  = grant_b;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.fill_start) begin
                    state_d    = ST_FILL;
                    cnt_d      = '0;
                    fill_val_d = bus.fill_value;
                end
                if (grant_a) begin
                    last_d = REQ_A;
                    if (!bus.a_we) a_rdata_d = ram_dout;
                end else if (grant_b) begin
                    last_d = REQ_B;
                    if (!bus.b_we) b_rdata_d = ram_dout;
                end
            end
            ST_FILL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(WORDS - 1)) begin
                    state_d     = ST_IDLE;
                    fill_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= LAST_INIT;
            cnt_q       <= '0;
            fill_val_q  <= '0;
            fill_done_q <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            fill_val_q  <= fill_val_d;
            fill_done_q <= fill_done_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    assign bus.a_ready   = grant_a;
    assign bus.b_ready   = grant_b;
    assign bus.a_rvalid  = a_rvalid_q;
    assign bus.b_rvalid  = b_rvalid_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.fill_busy = (state_q == ST_FILL);
    assign bus.fill_done = fill_done_q;

endmodule

// File: tb/tb_ram512_arbiter.sv
// tb/tb_ram512_arbiter.sv - randomized and directed bench for ram512_arbiter
module tb_ram512_arbiter;
    import ram512_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram512_arbiter_if bus();

    ram512_arbiter #(.FIRST_PRIO(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [15:0] mem [512];
    bit          m_last_b;
    bit          m_busy;
    int          m_idx;
    logic [15:0] m_fval;
    bit          m_done;
    bit          m_arv, m_brv;
    logic [15:0] m_ard, m_brd;

    bit g_a, g_b;
    bit d_a_ready, d_b_ready;
    int cnt_busy, cnt_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // one clock: called at a negedge with inputs already driven
    task automatic cycle();
        bit start;
        #1;
        start = 0; g_a = 0; g_b = 0;
        if (!m_busy) begin
            if (bus.fill_start) start = 1;
            else if (bus.a_valid && bus.b_valid) begin
                if (m_last_b) g_a = 1; else g_b = 1;
            end else begin
                g_a = bus.a_valid;
                g_b = bus.b_valid;
            end
        end
        d_a_ready = bus.a_ready;
        d_b_ready = bus.b_ready;
        chk("a_ready", bus.a_ready, g_a);
        chk("b_ready", bus.b_ready, g_b);
        chk("a_rvalid", bus.a_rvalid, m_arv);
        chk("b_rvalid", bus.b_rvalid, m_brv);
        chk("a_rdata", bus.a_rdata, m_ard);
        chk("b_rdata", bus.b_rdata, m_brd);
        chk("fill_busy", bus.fill_busy, m_busy);
        chk("fill_done", bus.fill_done, m_done);
        chk("rvalid_excl", bus.a_rvalid & bus.b_rvalid, 0);
        cnt_busy += int'(bus.fill_busy);
        cnt_done += int'(bus.fill_done);

        m_done = 0;
        m_arv = g_a;
        m_brv = g_b;
        if (g_a) begin
            if (bus.a_we) mem[bus.a_addr] = bus.a_wdata; else m_ard = mem[bus.a_addr];
            m_last_b = 0;
        end
        if (g_b) begin
            if (bus.b_we) mem[bus.b_addr] = bus.b_wdata; else m_brd = mem[bus.b_addr];
            m_last_b = 1;
        end
        if (m_busy) begin
            mem[m_idx] = m_fval;
            m_idx++;
            if (m_idx == 512) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (start) begin
            m_busy = 1;
            m_idx  = 0;
            m_fval = bus.fill_value;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.a_valid = 0; bus.b_valid = 0; bus.fill_start = 0;
        #1;
        m_busy = 0; m_done = 0; m_arv = 0; m_brv = 0;
        m_ard = '0; m_brd = '0; m_last_b = 1;
        chk("rst_fill_busy", bus.fill_busy, 0);
        chk("rst_fill_done", bus.fill_done, 0);
        chk("rst_a_rvalid", bus.a_rvalid, 0);
        chk("rst_b_rvalid", bus.b_rvalid, 0);
        chk("rst_a_rdata", bus.a_rdata, 0);
        chk("rst_b_rdata", bus.b_rdata, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic a_req(input bit we, input logic [8:0] addr, input logic [15:0] d);
        bus.a_valid = 1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = d;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            if (g_a) break;
        end
        if (!g_a) chk("a_req_timeout", 0, 1);
        bus.a_valid = 0;
    endtask

    task automatic b_req(input bit we, input logic [8:0] addr, input logic [15:0] d);
        bus.b_valid = 1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = d;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            if (g_b) break;
        end
        if (!g_b) chk("b_req_timeout", 0, 1);
        bus.b_valid = 0;
    endtask

    task automatic pulse_fill(input logic [15:0] v);
        bus.fill_start = 1; bus.fill_value = v;
        cycle();
        bus.fill_start = 0;
    endtask

    initial begin
        bus.a_valid = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_valid = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
        bus.fill_start = 0; bus.fill_value = '0;
        do_reset();

        // write then read back on A
        bus.a_valid = 1; bus.a_we = 1; bus.a_addr = 9'h005; bus.a_wdata = 16'hBEEF;
        cycle();
        chk("t1_wr_ready", d_a_ready, 1);
        bus.a_valid = 0;
        chk("t1_wr_rvalid", bus.a_rvalid, 1);
        a_req(0, 9'h005, '0);
        chk("t1_rd_rvalid", bus.a_rvalid, 1);
        chk("t1_rd_rdata", bus.a_rdata, 16'hBEEF);
        cycle();

        // write on A, read same word on B the next cycle
        a_req(1, 9'h1FF, 16'h1234);
        b_req(0, 9'h1FF, '0);
        chk("t3_b_rdata", bus.b_rdata, 16'h1234);
        cycle();

        // fill while A holds a request
        cnt_busy = 0; cnt_done = 0;
        bus.a_valid = 1; bus.a_we = 0; bus.a_addr = 9'h0FF;
        pulse_fill(16'hA5A5);
        for (int i = 0; i < 700 && !g_a; i++) cycle();
        bus.a_valid = 0;
        chk("fill_busy_len", cnt_busy, 512);
        chk("fill_done_cnt", cnt_done, 1);
        chk("fill_rd_0ff", bus.a_rdata, 16'hA5A5);
        a_req(0, 9'h000, '0);
        chk("fill_rd_000", bus.a_rdata, 16'hA5A5);
        a_req(0, 9'h1FF, '0);
        chk("fill_rd_1ff", bus.a_rdata, 16'hA5A5);
        cycle();

        // contended reads alternate starting with A after reset
        do_reset();
        bus.a_valid = 1; bus.a_we = 0; bus.a_addr = 9'($urandom);
        bus.b_valid = 1; bus.b_we = 0; bus.b_addr = 9'($urandom);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("alt_a_ready", d_a_ready, (k % 2 == 0));
            chk("alt_b_ready", d_b_ready, (k % 2 == 1));
            if (g_a) bus.a_addr = 9'($urandom);
            if (g_b) bus.b_addr = 9'($urandom);
        end
        bus.a_valid = 0; bus.b_valid = 0;
        cycle();

        // second fill_start mid-fill is ignored
        cnt_busy = 0; cnt_done = 0;
        pulse_fill(16'h3C3C);
        for (int i = 0; i < 200; i++) cycle();
        pulse_fill(16'h0F0F);
        for (int i = 0; i < 700 && cnt_done == 0; i++) cycle();
        chk("refill_busy_len", cnt_busy, 512);
        chk("refill_done_cnt", cnt_done, 1);
        a_req(0, 9'h123, '0);
        chk("refill_rd", bus.a_rdata, 16'h3C3C);

        // random traffic on both requesters
        for (int n = 0; n < 3000; n++) begin
            if (!bus.a_valid && $urandom_range(0, 2) != 0) begin
                bus.a_valid = 1; bus.a_we = 1'($urandom_range(0, 1));
                bus.a_addr = ($urandom_range(0, 1) != 0) ? 9'($urandom_range(0, 7)) : 9'($urandom);
                bus.a_wdata = 16'($urandom);
            end
            if (!bus.b_valid && $urandom_range(0, 2) != 0) begin
                bus.b_valid = 1; bus.b_we = 1'($urandom_range(0, 1));
                bus.b_addr = ($urandom_range(0, 1) != 0) ? 9'($urandom_range(0, 7)) : 9'($urandom);
                bus.b_wdata = 16'($urandom);
            end
            cycle();
            if (g_a) bus.a_valid = 0;
            if (g_b) bus.b_valid = 0;
        end
        bus.a_valid = 0; bus.b_valid = 0;
        cycle();

        // reset during a fill leaves memory partially written
        a_req(1, 9'h1F0, 16'h7777);
        a_req(0, 9'h1F0, '0);
        chk("pre_rd_1f0", bus.a_rdata, 16'h7777);
        cnt_done = 0;
        pulse_fill(16'h5A5A);
        for (int i = 0; i < 99; i++) cycle();
        reset = 1'b1;
        #1;
        chk("rst_fill_busy_now", bus.fill_busy, 0);
        do_reset();
        for (int i = 0; i < 600; i++) cycle();
        chk("rst_no_done", cnt_done, 0);
        a_req(0, 9'h010, '0);
        chk("rst_rd_010", bus.a_rdata, 16'h5A5A);
        a_req(0, 9'h1F0, '0);
        chk("rst_rd_1f0", bus.a_rdata, 16'h7777);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram512_arbiter.md
Name: ram512_arbiter

Overview:
- Shares one ram512 instance between two requesters, A and B, using round-robin arbitration with a valid/ready handshake.
- Includes a fill engine that sequentially writes a programmable value to all 512 words, for example to clear memory after boot.
- Sits between the CPU/DMA-side masters and the ram512 storage. ram512 has combinational read and a synchronous write on load.

Parameters:
- FIRST_PRIO, default 0, the requester favoured on the first contended cycle after reset (0 = A, 1 = B).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- a_valid  input  1  requester A has a request
- a_we  input  1  A request is a write (1) or a read (0)
- a_addr  input  9  A word address
- a_wdata  input  16  A write data
- a_ready  output  1  A request accepted this cycle (combinational)
- a_rvalid  output  1  A response valid (registered)
- a_rdata  output  16  A read data (registered)
- b_valid, b_we, b_addr, b_wdata, b_ready, b_rvalid, b_rdata: same as the A ports, for requester B
- fill_start  input  1  single-cycle pulse that starts a fill
- fill_value  input  16  value written by the fill; sampled when fill_start is accepted
- fill_busy  output  1  fill in progress
- fill_done  output  1  single-cycle pulse when the fill completes

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, fill_busy = 0, fill_done = 0.
  - a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0.
  - Round-robin pointer "last" = ~FIRST_PRIO.
  - RAM contents are not cleared by reset.
- FSM states are IDLE and FILL.
- IDLE, accepting at most one request per cycle:
  - If exactly one of a_valid or b_valid is high, that requester is granted.
  - If both are high, grant the requester not equal to last.
  - The granted requester's ready is driven high in the same cycle (ready depends combinationally on the valids and last).
  - last updates to the granted requester at the clock edge. When nothing is granted, last holds.
- Granted write:
  - The RAM load is asserted with the granted address and wdata, so the write takes effect at this edge.
  - The requester's rvalid pulses high for one cycle on the next cycle. rdata holds its previous value.
- Granted read:
  - The RAM output at the granted address is captured into that requester's rdata at the edge.
  - rvalid is high on the next cycle, giving a latency of 1.
- rvalid of a requester that was not granted is 0. rvalid is never high for both requesters in the same cycle.
- A read in the cycle after a write to the same address returns the new data.
- A request is held by the requester (valid stays high, fields stable) until ready is seen. The arbiter does not check this.
- Starting a fill:
  - fill_start in IDLE wins over any requests that cycle; no ready is asserted.
  - On that edge: state goes to FILL, counter = 0, fill_value is latched, and fill_busy is 1 from the next cycle.
- FILL:
  - Each cycle writes the latched value to address counter, then increments the counter (9-bit).
  - a_ready = b_ready = 0 throughout; requests stall.
  - The cycle with counter = 511 performs the last write. On that edge: state goes to IDLE, fill_busy goes to 0, and fill_done pulses for one cycle.
  - Total: 512 cycles with fill_busy high.
  - Arbitration resumes in the same cycle fill_done is high.
- fill_start during FILL is ignored; the fill does not restart.
- fill_start arriving together with reset: reset dominates.
- Reset during FILL: the block returns to IDLE immediately and the memory is left partially filled. No fill_done is issued.
- Address arithmetic is 9-bit; the counter wraps 511 -> 0 only at completion.

Decomposition:
- Shared package:
  - Constants ADDR_W = 9, DATA_W = 16, WORDS = 512.
  - Encodings for the FSM states IDLE and FILL.
  - Requester IDs REQ_A = 0, REQ_B = 1.
- The one sub-module is the existing ram512, instantiated once. The arbitration and fill muxing stay in this module.
- An optional rr_arb2 helper may be used, but is not required.

Test Plan:
- Reset, then A writes 16'hBEEF to address 9'h005, then A reads 9'h005:
  - Write: a_ready = 1 in the request cycle; a_rvalid pulses the next cycle.
  - Read: a_rdata = 16'hBEEF, with a_rvalid one cycle after a_ready.
- A and B both hold continuous valid reads (FIRST_PRIO = 0):
  - Grants alternate A, B, A, B.
  - b_ready stays 0 while A is granted.
  - No cycle has a_rvalid and b_rvalid both high.
- A writes 9'h1FF = 16'h1234; then B reads 9'h1FF the next cycle -> b_rdata = 16'h1234.
- fill_start with fill_value = 16'hA5A5 while A holds a valid request:
  - fill_busy stays high for 512 cycles with a_ready = 0 throughout.
  - fill_done pulses once, then A is granted.
  - Reads of 9'h000, 9'h0FF and 9'h1FF then return 16'hA5A5.
- A second fill_start in the middle of a fill -> ignored; fill_done occurs exactly 512 cycles after the first start.
- Reset asserted 100 cycles into a fill:
  - fill_busy = 0 immediately and no fill_done is seen.
  - Address 9'h010 reads the fill value; address 9'h1F0 keeps its prior contents.
